ps2_scan_receiver: RTL and testbench
====================================

# ps2_scan_receiver

Parametrised PS/2 keyboard receiver for the 27 MHz system domain. It oversamples the raw PS/2 clock and data lines and deserialises full 11-bit frames with start, parity and stop checking. It decodes the E0 (extended) and F0 (break) prefixes and queues complete key events in a FIFO. Downstream logic, such as the letter/number selection logic, drains events through a valid/ready handshake.

## Interface
- FIFO_DEPTH, 8, event FIFO entries; power of two, ≥2
- SYNC_STAGES, 2, synchroniser flops on keyboardClock/keyboardData; ≥2
- TIMEOUT_CYCLES, 27000, clock27 cycles without a PS/2 falling edge before a partial frame is abandoned (1 ms at 27 MHz)

Ports:
- clock27  in  1  system clock; all logic on rising edge
- resetN  in  1  asynchronous active-low reset
- keyboardClock  in  1  raw PS/2 clock, asynchronous
- keyboardData  in  1  raw PS/2 data, asynchronous
- keyValid  out  1  FIFO head holds an event
- keyReady  in  1  consumer accepts head event this cycle
- keyCode  out  8  scan code of head event
- keyBreak  out  1  head event is a release (F0 prefixed)
- keyExtended  out  1  head event is E0 prefixed
- frameError  out  1  one-cycle pulse per rejected frame
- overflow  out  1  sticky; an event was dropped because the FIFO was full
- fifoCount  out  $clog2(FIFO_DEPTH)+1  occupied entries

## Operation
- Both PS/2 lines pass through SYNC_STAGES flops. A falling edge is a synced-clock 1→0 transition, registered as a one-cycle strobe; all bit sampling uses synced data on that strobe.
- The frame FSM has states IDLE, DATA, PARITY, STOP.
  - IDLE: on strobe, data 0 → DATA with bitCnt=0. Data 1 → stay IDLE; this is a spurious edge and is not an error.
  - DATA: shift in LSB first; after the 8th bit → PARITY.
  - PARITY: capture bit; data bits plus parity must contain an odd number of ones. → STOP.
  - STOP: data must be 1. If parity and stop are both good, the byte goes to the prefix decoder. Otherwise pulse frameError and discard the byte. → IDLE in both cases.
- Timeout: a counter resets on every strobe and counts while the FSM is not in IDLE. When it reaches TIMEOUT_CYCLES, the FSM goes to IDLE and frameError pulses.
- Prefix decoder:
  - E0 sets extFlag; F0 sets brkFlag; neither byte is pushed.
  - Any other byte pushes {extFlag, brkFlag, byte} and then clears both flags.
  - Any frameError also clears both flags.
- FIFO is first-word-fall-through. keyValid = (fifoCount ≠ 0). keyCode, keyBreak and keyExtended always reflect the head entry and hold 0 when the FIFO is empty. A pop occurs when keyValid && keyReady.
- Push while full without a same-cycle pop: the event is dropped and overflow is set; overflow clears only on reset.
- Simultaneous push and pop: both take effect and fifoCount is unchanged. This applies when full, since the pop frees the slot. When the FIFO is empty only the push takes effect, because keyValid=0 means there is no pop.
- Read and write pointers wrap modulo FIFO_DEPTH.

## Timing
- All outputs are 0 during and after reset. This includes fifoCount, overflow and frameError. The FSM resets to IDLE, the flags clear and the pointers return to 0.
- Strobe latency is SYNC_STAGES+1 cycles after the raw falling edge.
- The push happens on the cycle after the STOP strobe. If the FIFO was empty, keyValid rises on the following cycle, with keyCode valid in that same cycle.
- Pop: the head advances on the clock edge where keyValid && keyReady. The next entry, or keyValid=0, is visible the following cycle.
- frameError is exactly one cycle wide, on the cycle after the STOP strobe or the timeout expiry.
- Reset asserted mid-frame abandons the partial byte and any pending prefix flags, and empties the FIFO.

## Configuration
- PS2_PREFIX_DECODE_EN defined: E0/F0 handling as above.
- PS2_PREFIX_DECODE_EN not defined:
  - Every good byte, including E0 and F0, is pushed raw.
  - keyBreak and keyExtended are tied to 0, and the FIFO width is 8 bits.

## Test plan
- Frame 1C (data 0x1C, parity 0, stop 1), keyReady=1 → one event: keyCode=1C, keyBreak=0, keyExtended=0; frameError stays 0.
- Frames F0,1C then E0,F0,75 → events {1C, brk=1, ext=0} then {75, brk=1, ext=1}; no events for the prefix bytes.
- Frame 1C with parity bit flipped, then a valid 32 → frameError pulses once; only event 32 is queued. Repeat with stop=0 → same result.
- 4 data bits then the line idle for TIMEOUT_CYCLES → frameError pulse and FSM back in IDLE; the next valid frame 23 is queued correctly.
- keyReady=0 with FIFO_DEPTH+1 frames → fifoCount=FIFO_DEPTH and overflow=1; draining returns the first FIFO_DEPTH codes in order. A push coinciding with a pop when full → no overflow, and fifoCount holds.
- resetN pulsed low after 5 bits of a frame following an F0 → all outputs 0; the next frame 1C is reported with keyBreak=0.

Source files
------------

// File: rtl/ps2_scan_receiver.sv
// ps2_scan_receiver: oversampling PS/2 keyboard receiver for the 27 MHz domain.
// Synchronises the raw PS/2 lines, deserialises 11-bit frames and checks
// start, parity and stop bits. Complete key events are queued in a
// first-word-fall-through FIFO that is drained through a valid/ready handshake.
// Optional feature macro: PS2_PREFIX_DECODE_EN. When it is defined, E0
// (extended) and F0 (break) prefixes are folded into the following event.
// When it is not defined, every good byte is queued raw.
module ps2_scan_receiver #(
  parameter int FIFO_DEPTH     = 8,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 27000
) (
  input  logic                          clock27,
  input  logic                          resetN,
  input  logic                          keyboardClock,
  input  logic                          keyboardData,
  output logic                          keyValid,
  input  logic                          keyReady,
  output logic [7:0]                    keyCode,
  output logic                          keyBreak,
  output logic                          keyExtended,
  output logic                          frameError,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifoCount
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
`ifdef PS2_PREFIX_DECODE_EN
  localparam int EW = 10;
`else
  localparam int EW = 8;
`endif
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
  localparam logic [TW-1:0] TIMEOUT_C = TW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  // Data bits plus parity bit must hold an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

  logic [SYNC_STAGES-1:0] kclk_sync_r;
  logic [SYNC_STAGES-1:0] kdat_sync_r;
  logic                   kclk_prev_r;
  logic                   kdat_r;
  logic                   strobe_r;

  state_t                 state_r;
  state_t                 state_nx_s;
  logic [2:0]             bit_cnt_r;
  logic [7:0]             shift_r;
  logic                   par_r;
  logic [TW-1:0]          tmo_cnt_r;
  logic                   timeout_s;
  logic                   frame_err_s;
  logic                   byte_ok_s;
  logic                   frame_err_r;
  logic                   byte_ok_r;
  logic [7:0]             byte_r;

  logic                   push_s;
  logic [EW-1:0]          push_data_s;
  logic                   pop_s;
  logic                   full_s;
  logic                   wr_en_s;
  logic [EW-1:0]          mem_r [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr_r;
  logic [AW-1:0]          rd_ptr_r;
  logic [CW-1:0]          count_r;
  logic                   overflow_r;
  logic [EW-1:0]          head_s;

  // Synchronise both PS/2 lines and derive the falling-edge strobe with aligned data.
  always_ff @(posedge clock27 or negedge resetN) begin
    if (!resetN) begin
      kclk_sync_r <= {SYNC_STAGES{1'b1}};
      kdat_sync_r <= {SYNC_STAGES{1'b1}};
      kclk_prev_r <= 1'b1;
      kdat_r      <= 1'b1;
      strobe_r    <= 1'b0;
    end else begin
      kclk_sync_r <= {kclk_sync_r[SYNC_STAGES-2:0], keyboardClock};
      kdat_sync_r <= {kdat_sync_r[SYNC_STAGES-2:0], keyboardData};
      kclk_prev_r <= kclk_sync_r[SYNC_STAGES-1];
      kdat_r      <= kdat_sync_r[SYNC_STAGES-1];
      strobe_r    <= kclk_prev_r & ~kclk_sync_r[SYNC_STAGES-1];
    end
  end

  // A strobe in the same cycle as expiry keeps the frame alive.
  assign timeout_s = (state_r != IDLE) && !strobe_r && (tmo_cnt_r == TIMEOUT_C);

  // Frame state register.
  always_ff @(posedge clock27 or negedge resetN) begin
    if (!resetN) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Frame next-state logic.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (strobe_r && !kdat_r) state_nx_s = DATA;
        else                     state_nx_s = IDLE;
      end
      DATA: begin
        if (timeout_s)                          state_nx_s = IDLE;
        else if (strobe_r && bit_cnt_r == 3'd7) state_nx_s = PARITY;
        else                                    state_nx_s = DATA;
      end
      PARITY: begin
        if (timeout_s)     state_nx_s = IDLE;
        else if (strobe_r) state_nx_s = STOP;
        else               state_nx_s = PARITY;
      end
      STOP: begin
        if (timeout_s)     state_nx_s = IDLE;
        else if (strobe_r) state_nx_s = IDLE;
        else               state_nx_s = STOP;
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // Frame outputs: accept or reject the byte at the stop bit, reject on timeout.
  always_comb begin
    frame_err_s = 1'b0;
    byte_ok_s   = 1'b0;
    case (state_r)
      IDLE: begin
        frame_err_s = 1'b0;
        byte_ok_s   = 1'b0;
      end
      DATA, PARITY: begin
        frame_err_s = timeout_s;
        byte_ok_s   = 1'b0;
      end
      STOP: begin
        if (timeout_s) begin
          frame_err_s = 1'b1;
        end else if (strobe_r) begin
          if (odd_parity_ok(shift_r, par_r) && kdat_r) byte_ok_s = 1'b1;
          else                                         frame_err_s = 1'b1;
        end else begin
          frame_err_s = 1'b0;
        end
      end
      default: begin
        frame_err_s = 1'b0;
        byte_ok_s   = 1'b0;
      end
    endcase
  end

  // Bit shifter, parity capture, timeout counter and registered frame results.
  always_ff @(posedge clock27 or negedge resetN) begin
    if (!resetN) begin
      bit_cnt_r   <= 3'd0;
      shift_r     <= 8'h00;
      par_r       <= 1'b0;
      tmo_cnt_r   <= {TW{1'b0}};
      frame_err_r <= 1'b0;
      byte_ok_r   <= 1'b0;
      byte_r      <= 8'h00;
    end else begin
      if (strobe_r) begin
        case (state_r)
          IDLE:    bit_cnt_r <= 3'd0;
          DATA: begin
            shift_r   <= {kdat_r, shift_r[7:1]};
            bit_cnt_r <= bit_cnt_r + 3'd1;
          end
          PARITY:  par_r <= kdat_r;
          default: par_r <= par_r;
        endcase
      end
      if (strobe_r || state_r == IDLE) tmo_cnt_r <= {TW{1'b0}};
      else if (tmo_cnt_r != TIMEOUT_C) tmo_cnt_r <= tmo_cnt_r + {{(TW-1){1'b0}}, 1'b1};
      frame_err_r <= frame_err_s;
      byte_ok_r   <= byte_ok_s;
      if (byte_ok_s) byte_r <= shift_r;
    end
  end

`ifdef PS2_PREFIX_DECODE_EN
  logic ext_flag_r;
  logic brk_flag_r;

  // Prefix flags: E0/F0 arm the flags, any other byte or a frame error clears them.
  always_ff @(posedge clock27 or negedge resetN) begin
    if (!resetN) begin
      ext_flag_r <= 1'b0;
      brk_flag_r <= 1'b0;
    end else if (frame_err_r) begin
      ext_flag_r <= 1'b0;
      brk_flag_r <= 1'b0;
    end else if (byte_ok_r) begin
      if (byte_r == 8'hE0) begin
        ext_flag_r <= 1'b1;
      end else if (byte_r == 8'hF0) begin
        brk_flag_r <= 1'b1;
      end else begin
        ext_flag_r <= 1'b0;
        brk_flag_r <= 1'b0;
      end
    end
  end

  // Only non-prefix bytes become events, tagged with the pending flags.
  always_comb begin
    push_s      = byte_ok_r && (byte_r != 8'hE0) && (byte_r != 8'hF0);
    push_data_s = {ext_flag_r, brk_flag_r, byte_r};
  end
`else
  // Every good byte becomes an event.
  always_comb begin
    push_s      = byte_ok_r;
    push_data_s = byte_r;
  end
`endif

  assign pop_s   = keyValid & keyReady;
  assign full_s  = (count_r == DEPTH_C);
  assign wr_en_s = push_s & (~full_s | pop_s);

  // FIFO pointers, occupancy and sticky overflow.
  always_ff @(posedge clock27 or negedge resetN) begin
    if (!resetN) begin
      wr_ptr_r   <= {AW{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
      count_r    <= {CW{1'b0}};
      overflow_r <= 1'b0;
    end else begin
      if (wr_en_s) wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      if (pop_s)   rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      case ({wr_en_s, pop_s})
        2'b10:   count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
        2'b01:   count_r <= count_r - {{(CW-1){1'b0}}, 1'b1};
        default: count_r <= count_r;
      endcase
      overflow_r <= overflow_r | (push_s & full_s & ~pop_s);
    end
  end

  // FIFO storage; contents are only observed through the occupancy-gated head.
  always_ff @(posedge clock27) begin
    if (wr_en_s) mem_r[wr_ptr_r] <= push_data_s;
  end

  assign head_s    = mem_r[rd_ptr_r];
  assign keyValid  = (count_r != {CW{1'b0}});
  assign keyCode   = keyValid ? head_s[7:0] : 8'h00;
`ifdef PS2_PREFIX_DECODE_EN
  assign keyBreak    = keyValid ? head_s[8] : 1'b0;
  assign keyExtended = keyValid ? head_s[9] : 1'b0;
`else
  assign keyBreak    = 1'b0;
  assign keyExtended = 1'b0;
`endif
  assign frameError = frame_err_r;
  assign overflow   = overflow_r;
  assign fifoCount  = count_r;

endmodule

// File: tb/tb_ps2_scan_receiver.sv
// tb_ps2_scan_receiver: directed bench for ps2_scan_receiver. Expectations for
// prefix handling follow PS2_PREFIX_DECODE_EN as seen by this file.
module tb_ps2_scan_receiver;

  localparam int DEPTH = 4;
  localparam int TMO   = 300;

  logic       clk;
  logic       resetN;
  logic       kclk;
  logic       kdat;
  logic       keyReady;
  logic       keyValid;
  logic [7:0] keyCode;
  logic       keyBreak;
  logic       keyExtended;
  logic       frameError;
  logic       overflow;
  logic [2:0] fifoCount;

  int total = 0;
  int bad   = 0;
  int fe_cnt = 0;
  int fe0;
  logic [9:0] got[$];

  ps2_scan_receiver #(
    .FIFO_DEPTH(DEPTH),
    .SYNC_STAGES(2),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clock27(clk),
    .resetN(resetN),
    .keyboardClock(kclk),
    .keyboardData(kdat),
    .keyValid(keyValid),
    .keyReady(keyReady),
    .keyCode(keyCode),
    .keyBreak(keyBreak),
    .keyExtended(keyExtended),
    .frameError(frameError),
    .overflow(overflow),
    .fifoCount(fifoCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record error-pulse cycles and every accepted event {ext, brk, code}.
  always @(negedge clk) begin
    if (frameError === 1'b1) fe_cnt++;
    if (keyValid === 1'b1 && keyReady === 1'b1) got.push_back({keyExtended, keyBreak, keyCode});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_next(input string tag, input logic [7:0] code, input logic brk, input logic ext);
    logic [9:0] e;
    if (got.size() != 0) e = got.pop_front();
    else e = 10'h3FF;
    check(tag, {22'd0, e}, {22'd0, ext, brk, code});
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk);
    #2 keyReady = v;
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk);
    kdat = b;
    repeat (4) @(negedge clk);
    kclk = 1'b0;
    repeat (8) @(negedge clk);
    kclk = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  // Full frame; sync_pop raises keyReady for exactly the push cycle of this frame.
  task automatic send_frame(input logic [7:0] b, input logic flip, input logic stopv, input logic sync_pop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(~(^b) ^ flip);
    if (sync_pop) begin
      @(negedge clk);
      kdat = stopv;
      repeat (4) @(negedge clk);
      kclk = 1'b0;
      repeat (4) @(posedge clk);
      #2 keyReady = 1'b1;
      @(posedge clk);
      #2 keyReady = 1'b0;
      repeat (4) @(negedge clk);
      kclk = 1'b1;
      repeat (4) @(negedge clk);
    end else begin
      send_bit(stopv);
    end
    kdat = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic send_partial();
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(i[0]);
    kdat = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, {31'd0, keyValid}, 32'd0);
    check({tag, "_code"}, {24'd0, keyCode}, 32'd0);
    check({tag, "_brk"}, {31'd0, keyBreak}, 32'd0);
    check({tag, "_ext"}, {31'd0, keyExtended}, 32'd0);
    check({tag, "_ferr"}, {31'd0, frameError}, 32'd0);
    check({tag, "_ovf"}, {31'd0, overflow}, 32'd0);
    check({tag, "_count"}, {29'd0, fifoCount}, 32'd0);
  endtask

  initial begin
    resetN   = 1'b0;
    kclk     = 1'b1;
    kdat     = 1'b1;
    keyReady = 1'b0;
    repeat (5) @(negedge clk);
    check_all_zero("reset");
    resetN = 1'b1;
    repeat (5) @(negedge clk);

    // Single good frame with consumer always ready.
    set_ready(1'b1);
    fe0 = fe_cnt;
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    check_next("t1_event", 8'h1C, 1'b0, 1'b0);
    check("t1_nomore", got.size(), 32'd0);
    check("t1_noerr", fe_cnt - fe0, 32'd0);
    check("t1_empty", {31'd0, keyValid}, 32'd0);

    // Prefix sequences.
    send_frame(8'hF0, 1'b0, 1'b1, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    send_frame(8'hE0, 1'b0, 1'b1, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b1, 1'b0);
    send_frame(8'h75, 1'b0, 1'b1, 1'b0);
`ifdef PS2_PREFIX_DECODE_EN
    check_next("t2_brk1c", 8'h1C, 1'b1, 1'b0);
    check_next("t2_extbrk75", 8'h75, 1'b1, 1'b1);
`else
    check_next("t2_rawf0", 8'hF0, 1'b0, 1'b0);
    check_next("t2_raw1c", 8'h1C, 1'b0, 1'b0);
    check_next("t2_rawe0", 8'hE0, 1'b0, 1'b0);
    check_next("t2_rawf0b", 8'hF0, 1'b0, 1'b0);
    check_next("t2_raw75", 8'h75, 1'b0, 1'b0);
`endif
    check("t2_nomore", got.size(), 32'd0);

    // Parity error then good frame.
    fe0 = fe_cnt;
    send_frame(8'h1C, 1'b1, 1'b1, 1'b0);
    send_frame(8'h32, 1'b0, 1'b1, 1'b0);
    check("t3_par_err", fe_cnt - fe0, 32'd1);
    check_next("t3_par_32", 8'h32, 1'b0, 1'b0);
    check("t3_par_nomore", got.size(), 32'd0);

    // Stop error then good frame.
    fe0 = fe_cnt;
    send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
    send_frame(8'h32, 1'b0, 1'b1, 1'b0);
    check("t3_stop_err", fe_cnt - fe0, 32'd1);
    check_next("t3_stop_32", 8'h32, 1'b0, 1'b0);
    check("t3_stop_nomore", got.size(), 32'd0);

    // Abandoned partial frame.
    fe0 = fe_cnt;
    send_partial();
    repeat (TMO - 50) @(negedge clk);
    check("t4_before_tmo", fe_cnt - fe0, 32'd0);
    repeat (100) @(negedge clk);
    check("t4_after_tmo", fe_cnt - fe0, 32'd1);
    send_frame(8'h23, 1'b0, 1'b1, 1'b0);
    check_next("t4_23", 8'h23, 1'b0, 1'b0);
    check("t4_noextra_err", fe_cnt - fe0, 32'd1);
    check("t4_nomore", got.size(), 32'd0);

    // Fill FIFO, then push coinciding with pop while full, then overflow.
    set_ready(1'b0);
    send_frame(8'h15, 1'b0, 1'b1, 1'b0);
    send_frame(8'h16, 1'b0, 1'b1, 1'b0);
    send_frame(8'h1E, 1'b0, 1'b1, 1'b0);
    send_frame(8'h26, 1'b0, 1'b1, 1'b0);
    check("t5_full_count", {29'd0, fifoCount}, 32'd4);
    check("t5_full_noovf", {31'd0, overflow}, 32'd0);
    check("t5_head", {24'd0, keyCode}, 32'h15);
    send_frame(8'h25, 1'b0, 1'b1, 1'b1);
    check("t5_sync_count", {29'd0, fifoCount}, 32'd4);
    check("t5_sync_noovf", {31'd0, overflow}, 32'd0);
    check_next("t5_sync_pop", 8'h15, 1'b0, 1'b0);
    send_frame(8'h2E, 1'b0, 1'b1, 1'b0);
    check("t5_ovf_count", {29'd0, fifoCount}, 32'd4);
    check("t5_ovf", {31'd0, overflow}, 32'd1);
    check("t5_ovf_head", {24'd0, keyCode}, 32'h16);
    set_ready(1'b1);
    repeat (20) @(negedge clk);
    check_next("t5_d0", 8'h16, 1'b0, 1'b0);
    check_next("t5_d1", 8'h1E, 1'b0, 1'b0);
    check_next("t5_d2", 8'h26, 1'b0, 1'b0);
    check_next("t5_d3", 8'h25, 1'b0, 1'b0);
    check("t5_drained", got.size(), 32'd0);
    check("t5_count0", {29'd0, fifoCount}, 32'd0);
    check("t5_ovf_sticky", {31'd0, overflow}, 32'd1);

    // Reset mid-frame after a break prefix with an event pending.
    set_ready(1'b0);
    send_frame(8'h16, 1'b0, 1'b1, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b1, 1'b0);
    send_partial();
    @(negedge clk);
    resetN = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("t6_reset");
    resetN = 1'b1;
    repeat (5) @(negedge clk);
    got.delete();
    set_ready(1'b1);
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    check_next("t6_1c", 8'h1C, 1'b0, 1'b0);
    check("t6_nomore", got.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
